// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: iterative AES-128 inverse key schedule; emits round keys 10..0 over valid/ready.
// Ports: clk, rst (async, active-high), start_i/last_key_i (load the round-10 key),
// key_o/round_o/key_valid_o/key_ready_i (key stream), busy_o, done_o (pulse after round 0).
// Macro AES_INV_KEY_EQUIV_EN: key_o carries InvMixColumns of rounds 9..1 (equivalent inverse cipher keys).
module aes_inv_key_sched #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [127:0] last_key_i,
  output logic [127:0] key_o,
  output logic [3:0]   round_o,
  output logic         key_valid_o,
  input  logic         key_ready_i,
  output logic         busy_o,
  output logic         done_o
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [87:0] RCON = 88'h0001020408102040801b36;
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state_q, state_d;
  logic [127:0] key_q, nxt;
  logic [3:0] round_q;
  logic done_q, hs;
  logic [31:0] c0, c1, c2, c3, p0, p1, p2, p3, rw, sw;
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047-8*int'(b) -: 8];
  endfunction
  // row-major bus <-> word-major {W0,W1,W2,W3}; the transpose is its own inverse
  function automatic logic [127:0] tr(input logic [127:0] k);
    logic [127:0] t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[127-32*c-8*r -: 8] = k[127-32*r-8*c -: 8];
    return t;
  endfunction
`ifdef AES_INV_KEY_EQUIV_EN
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  // multiply by 09/0b/0d/0e: every such constant has bit 3 set, bits 2..0 pick the rest
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] x2, x4;
    x2 = xt(a);
    x4 = xt(x2);
    return xt(x4) ^ (c[2] ? x4 : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[0] ? a : 8'h00);
  endfunction
  function automatic logic [31:0] imc(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
            gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
            gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
            gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
  endfunction
`endif
  assign hs = state_q == EMIT && key_ready_i;
  assign {c0, c1, c2, c3} = tr(key_q);
  assign p3 = c3 ^ c2;
  assign p2 = c2 ^ c1;
  assign p1 = c1 ^ c0;
  assign rw = {p3[23:0], p3[31:24]};
  assign sw = {sbox(rw[31:24]), sbox(rw[23:16]), sbox(rw[15:8]), sbox(rw[7:0])};
  assign p0 = c0 ^ sw ^ {RCON[87-8*int'(round_q) -: 8], 24'h0};
  assign nxt = tr({p0, p1, p2, p3});
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? (start_i ? EMIT : IDLE) : (key_ready_i && round_q == 4'd0 ? IDLE : EMIT);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      key_q <= '0;
      round_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= hs && round_q == 4'd0;
      if (state_q == IDLE && start_i) begin
        key_q <= last_key_i;
        round_q <= 4'(NUM_ROUNDS);
      end else if (hs && round_q != 4'd0) begin
        key_q <= nxt;
        round_q <= round_q - 4'd1;
      end
    end
  always_comb begin
    key_valid_o = state_q == EMIT;
    busy_o = state_q == EMIT;
    round_o = round_q;
    done_o = done_q;
`ifdef AES_INV_KEY_EQUIV_EN
    key_o = round_q != 4'd0 && round_q != 4'(NUM_ROUNDS) ? tr({imc(c0), imc(c1), imc(c2), imc(c3)}) : key_q;
`else
    key_o = key_q;
`endif
  end
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// tb_aes_inv_key_sched: directed FIPS-197 A.1 vectors for the inverse key schedule.
module tb_aes_inv_key_sched;
  logic clk = 1'b0, rst = 1'b1, start_i = 1'b0, key_ready_i = 1'b0;
  logic [127:0] last_key_i = '0, key_o;
  logic [3:0] round_o;
  logic key_valid_o, busy_o, done_o;
  int checks = 0, failures = 0;
  logic [127:0] exp_k [0:10];
  logic [127:0] k10;
  aes_inv_key_sched dut (
    .clk(clk), .rst(rst), .start_i(start_i), .last_key_i(last_key_i),
    .key_o(key_o), .round_o(round_o), .key_valid_o(key_valid_o),
    .key_ready_i(key_ready_i), .busy_o(busy_o), .done_o(done_o)
  );
  always #5 clk = ~clk;
  function automatic logic [127:0] tr(input logic [127:0] k);
    logic [127:0] t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[127-32*c-8*r -: 8] = k[127-32*r-8*c -: 8];
    return t;
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [127:0] imc_words(input logic [127:0] w);
    logic [127:0] o;
    logic [31:0] mtx;
    mtx = 32'h0e0b0d09;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        o[127-32*c-8*r -: 8] = 8'h00;
        for (int j = 0; j < 4; j++)
          o[127-32*c-8*r -: 8] ^= gmul(mtx[31-8*((j-r+4)%4) -: 8], w[127-32*c-8*j -: 8]);
      end
    return o;
  endfunction
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_key(input string nm, input int e);
    checks++;
    if (key_valid_o !== 1'b1 || busy_o !== 1'b1 || round_o !== 4'(e) || key_o !== exp_k[e] || done_o !== 1'b0) begin
      failures++;
      $display("FAIL %s r%0d: valid=%b busy=%b done=%b round=%0d key=%h, want valid=1 busy=1 done=0 round=%0d key=%h",
               nm, e, key_valid_o, busy_o, done_o, round_o, key_o, e, exp_k[e]);
    end
  endtask
  task automatic chk_idle(input string nm, input logic d, input logic [3:0] r, input logic [127:0] k);
    checks++;
    if (key_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== d || round_o !== r || key_o !== k) begin
      failures++;
      $display("FAIL %s: valid=%b busy=%b done=%b round=%0d key=%h, want valid=0 busy=0 done=%b round=%0d key=%h",
               nm, key_valid_o, busy_o, done_o, round_o, key_o, d, r, k);
    end
  endtask
  task automatic test_reset;
    #3;
    chk_idle("reset_state", 1'b0, 4'd0, '0);
    cyc;
    rst = 1'b0;
    key_ready_i = 1'b1;
    repeat (3) cyc;
    chk_idle("ready_without_valid", 1'b0, 4'd0, '0);
    key_ready_i = 1'b0;
  endtask
  task automatic test_full_walk;
    start_i = 1'b1;
    last_key_i = k10;
    key_ready_i = 1'b1;
    cyc;
    start_i = 1'b0;
    for (int e = 10; e >= 0; e--) begin
      chk_key("walk", e);
      cyc;
    end
    chk_idle("walk_done", 1'b1, 4'd0, exp_k[0]);
    cyc;
    chk_idle("walk_done_clear", 1'b0, 4'd0, exp_k[0]);
  endtask
  task automatic test_backpressure;
    int e = 10, n = 0;
    bit fin = 0;
    start_i = 1'b1;
    last_key_i = k10;
    key_ready_i = 1'b0;
    cyc;
    start_i = 1'b0;
    while (!fin && n < 300) begin
      key_ready_i = 1'($urandom_range(0, 1));
      chk_key("bp", e);
      if (key_ready_i) begin
        if (e == 0) fin = 1;
        else e--;
      end
      cyc;
      n++;
    end
    checks++;
    if (!fin) begin
      failures++;
      $display("FAIL bp_timeout: reached round %0d after %0d cycles, want round 0 accepted", e, n);
    end
    chk_idle("bp_done", 1'b1, 4'd0, exp_k[0]);
    key_ready_i = 1'b0;
    cyc;
  endtask
  task automatic test_start_while_busy;
    start_i = 1'b1;
    last_key_i = k10;
    key_ready_i = 1'b1;
    cyc;
    start_i = 1'b0;
    for (int e = 10; e >= 0; e--) begin
      start_i = e <= 6 && e >= 4;
      last_key_i = e <= 6 ? exp_k[3] : k10;
      chk_key("busy_start", e);
      cyc;
    end
    start_i = 1'b0;
    last_key_i = k10;
    chk_idle("busy_start_done", 1'b1, 4'd0, exp_k[0]);
  endtask
  task automatic test_done_restart;
    start_i = 1'b1;
    last_key_i = k10;
    key_ready_i = 1'b0;
    cyc;
    start_i = 1'b0;
    chk_key("restart_in_done", 10);
  endtask
  task automatic test_async_reset;
    key_ready_i = 1'b1;
    for (int e = 10; e > 4; e--) cyc;
    chk_key("pre_reset", 4);
    #2 rst = 1'b1;
    #1;
    chk_idle("async_reset_now", 1'b0, 4'd0, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc;
    chk_idle("async_reset_no_done", 1'b0, 4'd0, '0);
    start_i = 1'b1;
    last_key_i = k10;
    key_ready_i = 1'b0;
    cyc;
    start_i = 1'b0;
    chk_key("after_reset", 10);
    key_ready_i = 1'b1;
    cyc;
    chk_key("after_reset", 9);
  endtask
  initial begin
    exp_k[0]  = tr(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    exp_k[1]  = tr(128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    exp_k[2]  = tr(128'hf2c295f2_7a96b943_5935807a_7359f67f);
    exp_k[3]  = tr(128'h3d80477d_4716fe3e_1e237e44_6d7a883b);
    exp_k[4]  = tr(128'hef44a541_a8525b7f_b671253b_db0bad00);
    exp_k[5]  = tr(128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc);
    exp_k[6]  = tr(128'h6d88a37a_110b3efd_dbf98641_ca0093fd);
    exp_k[7]  = tr(128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f);
    exp_k[8]  = tr(128'head27321_b58dbad2_312bf560_7f8d292f);
    exp_k[9]  = tr(128'hac7766f3_19fadc21_28d12941_575c006e);
    exp_k[10] = tr(128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    k10 = exp_k[10];
`ifdef AES_INV_KEY_EQUIV_EN
    for (int r = 1; r <= 9; r++) exp_k[r] = tr(imc_words(tr(exp_k[r])));
`endif
    test_reset;
    test_full_walk;
    test_backpressure;
    test_start_while_busy;
    test_done_restart;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_inv_key_sched.md
Name: aes_inv_key_sched

Overview:
- Iterative AES-128 inverse key schedule for the decryption datapath.
- Takes the final (round 10) round key and emits round keys 10, 9, …, 0 in decreasing order over a valid/ready stream.
- One round per accepted key: a one-cycle inverse expansion step per handshake.
- Feeds the decrypt round engine, so no 176-byte forward-expanded key store is needed.

Parameters:
- NUM_ROUNDS, 10, number of rounds; the key stream carries NUM_ROUNDS+1 keys. Only 10 (AES-128) is supported.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start_i  input  1  load last_key_i and begin a sequence; honoured only when busy_o=0
- last_key_i  input  128  round-10 key, row-major layout (see Behaviour)
- key_o  output  128  current round key, same layout
- round_o  output  4  round index of key_o (10 down to 0)
- key_valid_o  output  1  key_o/round_o valid
- key_ready_i  input  1  consumer accepts key when high with key_valid_o
- busy_o  output  1  sequence in progress
- done_o  output  1  one-cycle pulse after round-0 key accepted

Behaviour:
- Layout: byte(row r, col c) = bits [127-32r-8c -: 8]. Word Wc = {byte(0,c), byte(1,c), byte(2,c), byte(3,c)}; row-0 byte is the MSB.
- States: IDLE, EMIT.
- Reset (async, any state): state=IDLE, key register=0, round=0. Outputs: key_o=0, round_o=0, key_valid_o=0, busy_o=0, done_o=0.
- IDLE:
  - start_i=1 latches last_key_i and sets round=10.
  - Next cycle: EMIT, key_valid_o=1, busy_o=1.
  - Latency start→first valid = 1 cycle.
- EMIT:
  - key_valid_o held high; key_o and round_o stable until the handshake.
  - On key_valid_o&key_ready_i with round>0: register <= inverse step of current key; round <= round-1. Next key is valid in the following cycle.
  - With ready held high, one key per cycle; 11 handshakes total.
- EMIT, handshake with round=0:
  - Go to IDLE; key_valid_o=0 and busy_o=0 next cycle.
  - done_o=1 for exactly that one cycle.
  - Key register retains the round-0 key.
- Inverse step, current words C0..C3 of round r (r=10..1):
  - P3=C3^C2; P2=C2^C1; P1=C1^C0.
  - P0 = C0 ^ SubWord(RotWord(P3)) ^ {Rcon[r],24'h0}.
  - RotWord({a0,a1,a2,a3}) = {a1,a2,a3,a0}.
  - SubWord applies the forward AES S-box to each byte (4 S-box instances).
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Boundaries:
  - start_i while busy_o=1 is ignored: no restart, no reload.
  - start_i in the done_o cycle (state already IDLE) is accepted.
  - key_ready_i while key_valid_o=0 is ignored.
  - A reset mid-sequence aborts immediately with no done_o pulse.
- No combinational path from key_ready_i to key_valid_o.

Optional Feature:
- Macro AES_INV_KEY_EQUIV_EN selects the output form.
- Defined: for rounds 9..1, key_o = InvMixColumns(register), applied per column Wc (equivalent inverse cipher keys). Rounds 10 and 0 are output unmodified. The internal schedule register is never transformed.
- Undefined: key_o = register for every round; no InvMixColumns logic is instantiated.

Test Plan:
- Vector source: FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, round-10 key d014f9a8c9ee2589e13f0cc8b6630ca6. Word strings map to W0..W3 per the layout.
- Full walk: load round-10 key with ready=1 → 11 consecutive keys.
  - Round 10 → d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
  - Round 9 → ac7766f3 19fadc21 28d12941 575c006e.
  - Round 0 → 2b7e1516 28aed2a6 abf71588 09cf4f3c.
  - done_o pulses one cycle after round 0 is accepted.
- Backpressure: ready toggled randomly → key_o/round_o stable while valid&!ready; same 11-key sequence; no skips or repeats.
- Start while busy: assert start_i with a different key at round 6 → ignored; sequence completes with the original keys.
- Async reset at round 4 mid-handshake → all outputs 0 immediately, no done_o; a new start_i then yields round 10 correctly.
- AES_INV_KEY_EQUIV_EN defined:
  - Round 9 key_o = InvMixColumns of ac7766f3…575c006e, checked against a model.
  - Rounds 10 and 0 equal the plain values.
  - Undefined build: all 11 keys equal the plain values.
